// File: rtl/serial_mag_comparator_if.sv
// Handshake and operand bundle for the bit-serial magnitude comparator.
// The master issues compares; the slave (the comparator) returns the one-hot result.
interface serial_mag_comparator_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, a_in, b_in,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: scans operands MSB first, one bit per clock,
// and reports a registered one-hot GT/EQ/LT result alongside a single-cycle done pulse.
module serial_mag_comparator #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    serial_mag_comparator_if.slave bus
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IdxW-1:0]  idx_q;
    logic             found_q;
    logic             rec_gt_q;
    logic             busy_q;
    logic             done_q;
    logic             gt_q;
    logic             eq_q;
    logic             lt_q;

    logic bit_gt;
    logic bit_lt;
    logic bit_diff;
    logic last_bit;

    // 1-bit compare cell on the currently selected operand bit.
    always_comb begin
        bit_gt   = a_q[idx_q] & ~b_q[idx_q];
        bit_lt   = ~a_q[idx_q] & b_q[idx_q];
        bit_diff = bit_gt | bit_lt;
        last_bit = (idx_q == '0) || (EARLY_EXIT && bit_diff);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            found_q  <= 1'b0;
            rec_gt_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q      <= bus.a_in;
                        b_q      <= bus.b_in;
                        idx_q    <= IdxW'(WIDTH - 1);
                        found_q  <= 1'b0;
                        rec_gt_q <= 1'b0;
                        gt_q     <= 1'b0;
                        eq_q     <= 1'b0;
                        lt_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= StCompare;
                    end
                end
                StCompare: begin
                    // Only the MSB-most difference is kept; later bits cannot override it.
                    if (!found_q && bit_diff) begin
                        found_q  <= 1'b1;
                        rec_gt_q <= bit_gt;
                    end
                    if (last_bit) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        gt_q    <= found_q ? rec_gt_q : bit_gt;
                        lt_q    <= found_q ? ~rec_gt_q : bit_lt;
                        eq_q    <= ~found_q & ~bit_diff;
                    end else begin
                        idx_q <= idx_q - IdxW'(1);
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Self-checking bench: four comparator variants share one stimulus stream; a per-DUT
// scoreboard of expected results and latencies is popped whenever a done pulse appears.
module tb_serial_mag_comparator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a16;
    logic [15:0] b16;

    always #5 clk = ~clk;

    serial_mag_comparator_if #(.WIDTH(8))  if8e ();
    serial_mag_comparator_if #(.WIDTH(8))  if8n ();
    serial_mag_comparator_if #(.WIDTH(1))  if1 ();
    serial_mag_comparator_if #(.WIDTH(16)) if16 ();

    assign if8e.start = start;
    assign if8e.a_in  = a16[7:0];
    assign if8e.b_in  = b16[7:0];
    assign if8n.start = start;
    assign if8n.a_in  = a16[7:0];
    assign if8n.b_in  = b16[7:0];
    assign if1.start  = start;
    assign if1.a_in   = a16[0:0];
    assign if1.b_in   = b16[0:0];
    assign if16.start = start;
    assign if16.a_in  = a16;
    assign if16.b_in  = b16;

    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_8e (.clk(clk), .rst(rst), .bus(if8e));
    serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_8n (.clk(clk), .rst(rst), .bus(if8n));
    serial_mag_comparator #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_1 (.clk(clk), .rst(rst), .bus(if1));
    serial_mag_comparator #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_16 (.clk(clk), .rst(rst), .bus(if16));

    logic [3:0] done_v, busy_v, gt_v, eq_v, lt_v;
    assign done_v = {if16.done, if1.done, if8n.done, if8e.done};
    assign busy_v = {if16.busy, if1.busy, if8n.busy, if8e.busy};
    assign gt_v   = {if16.gt, if1.gt, if8n.gt, if8e.gt};
    assign eq_v   = {if16.eq, if1.eq, if8n.eq, if8e.eq};
    assign lt_v   = {if16.lt, if1.lt, if8n.lt, if8e.lt};

    typedef struct {
        logic gt;
        logic eq;
        logic lt;
        int   lat;
    } exp_t;

    exp_t sb [4][$];
    exp_t last_e [4];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic int width_of(int i);
        case (i)
            0, 1:    return 8;
            2:       return 1;
            default: return 16;
        endcase
    endfunction

    function automatic exp_t model(int i, logic [15:0] a, logic [15:0] b);
        exp_t        e;
        int          w = width_of(i);
        logic [15:0] m = (w == 16) ? 16'hffff : 16'((32'd1 << w) - 1);
        logic [15:0] am = a & m;
        logic [15:0] bm = b & m;
        e.gt  = am > bm;
        e.eq  = am == bm;
        e.lt  = am < bm;
        e.lat = w;
        if (i != 1) begin
            for (int k = w - 1; k >= 0; k--) begin
                if (am[k] != bm[k]) begin
                    e.lat = w - k;
                    break;
                end
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic check_done(input int i, input int n);
        exp_t e;
        n_cmp++;
        assert (sb[i].size() != 0) else begin
            n_err++;
            $error("FAIL sb_underflow dut%0d: observed unexpected done expected none", i);
        end
        if (sb[i].size() != 0) begin
            e = sb[i].pop_front();
            chk($sformatf("gt dut%0d", i), 32'(gt_v[i]), 32'(e.gt));
            chk($sformatf("eq dut%0d", i), 32'(eq_v[i]), 32'(e.eq));
            chk($sformatf("lt dut%0d", i), 32'(lt_v[i]), 32'(e.lt));
            chk($sformatf("latency dut%0d", i), 32'(n), 32'(e.lat));
            chk($sformatf("busy_at_done dut%0d", i), 32'(busy_v[i]), 32'd1);
        end
    endtask

    // One compare on all DUTs; operands are scrambled right after acceptance.
    task automatic run(input logic [15:0] a, input logic [15:0] b);
        logic [3:0] pending = 4'hf;
        logic [3:0] hg, he, hl;
        int         n = 0;
        @(negedge clk);
        a16   = a;
        b16   = b;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            last_e[i] = model(i, a, b);
            sb[i].push_back(last_e[i]);
        end
        @(negedge clk);
        start = 1'b0;
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        while (pending != 4'h0 && n < 40) begin
            for (int i = 0; i < 4; i++) begin
                if (pending[i] && done_v[i]) begin
                    check_done(i, n);
                    pending[i] = 1'b0;
                end
            end
            if (pending != 4'h0) begin
                n++;
                @(negedge clk);
            end
        end
        chk("timeout_pending", 32'(pending), 32'd0);
        @(negedge clk);
        chk("idle_busy", 32'(busy_v), 32'd0);
        chk("idle_done", 32'(done_v), 32'd0);
        for (int i = 0; i < 4; i++) begin
            hg[i] = last_e[i].gt;
            he[i] = last_e[i].eq;
            hl[i] = last_e[i].lt;
        end
        chk("hold_gt", 32'(gt_v), 32'(hg));
        chk("hold_eq", 32'(eq_v), 32'(he));
        chk("hold_lt", 32'(lt_v), 32'(hl));
    endtask

    initial begin
        exp_t       e;
        int         pulses;
        int         n1;
        int         n2;
        logic [3:0] seen;
        logic [15:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        a16   = '0;
        b16   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy_v), 32'd0);
        chk("rst_done", 32'(done_v), 32'd0);
        chk("rst_gt", 32'(gt_v), 32'd0);
        chk("rst_eq", 32'(eq_v), 32'd0);
        chk("rst_lt", 32'(lt_v), 32'd0);

        run(16'h0080, 16'h007f);
        run(16'h003c, 16'h003d);
        run(16'h00a5, 16'h00a5);
        run(16'hffff, 16'h0000);
        run(16'h0000, 16'h0001);

        // start held high: second accept only after the idle cycle following done.
        @(negedge clk);
        a16    = 16'h0012;
        b16    = 16'h0034;
        start  = 1'b1;
        e      = model(1, a16, b16);
        pulses = 0;
        n1     = -1;
        n2     = -1;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge clk);
            if (done_v[1]) begin
                pulses++;
                chk("hold_start_gt", 32'(gt_v[1]), 32'(e.gt));
                chk("hold_start_lt", 32'(lt_v[1]), 32'(e.lt));
                if (n1 < 0) n1 = n;
                else n2 = n;
            end
            if (n1 >= 0 && n == n1 + 1) chk("hold_start_idle_gap", 32'(busy_v[1]), 32'd0);
            if (n1 >= 0 && n == n1 + 2) begin
                chk("hold_start_reaccept", 32'(busy_v[1]), 32'd1);
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("hold_start_pulses", 32'(pulses), 32'd2);
        chk("hold_start_first", 32'(n1), 32'd8);
        chk("hold_start_second", 32'(n2), 32'd18);
        repeat (20) @(negedge clk);

        // Reset while the non-early-exit DUT sits at idx 4.
        @(negedge clk);
        a16   = 16'h003c;
        b16   = 16'h003d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy_v), 32'd0);
        chk("midrst_done", 32'(done_v), 32'd0);
        chk("midrst_gt", 32'(gt_v), 32'd0);
        chk("midrst_eq", 32'(eq_v), 32'd0);
        chk("midrst_lt", 32'(lt_v), 32'd0);
        seen = '0;
        repeat (12) begin
            @(negedge clk);
            seen |= done_v;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        run(16'h5a00, 16'h5a01);

        for (int r = 0; r < 30; r++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ 16'(32'd1 << $urandom_range(0, 15));
                default: rb = 16'($urandom);
            endcase
            run(ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
